// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg: shared state encoding for the CPU clock-enable sequencer
package clock_ctrl_pkg;
  localparam logic [1:0] STATE_HALT = 2'd0;
  localparam logic [1:0] STATE_RUN  = 2'd1;
  localparam logic [1:0] STATE_STEP = 2'd2;
  typedef enum logic [1:0] {
    HALT = STATE_HALT,
    RUN  = STATE_RUN,
    STEP = STATE_STEP
  } ctrl_state_t;
endpackage

// File: rtl/clock_controller_if.sv
// clock_controller_if: run/step controls, ratio load port and tick outputs
interface clock_controller_if #(parameter int WIDTH = 32);
  logic             cmd_run;
  logic             step_req;
  logic             cfg_valid;
  logic [WIDTH-1:0] cfg_ratio;
  logic             cfg_ready;
  logic             tick;
  logic [WIDTH-1:0] tick_count;
  logic [1:0]       state;
  modport master (
    output cmd_run, step_req, cfg_valid, cfg_ratio,
    input  cfg_ready, tick, tick_count, state
  );
  modport slave (
    input  cmd_run, step_req, cfg_valid, cfg_ratio,
    output cfg_ready, tick, tick_count, state
  );
endinterface

// File: rtl/rising_edge_detect.sv
// rising_edge_detect: one-cycle pulse on each low-to-high transition of d
module rising_edge_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic pulse
);
  logic step_prev;
  // remember last level so a held-high input yields only one pulse
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) step_prev <= 1'b0;
    else step_prev <= d;
  assign pulse = d & ~step_prev;
endmodule

// File: rtl/clock_controller.sv
// clock_controller: run/halt/single-step sequencer producing a one-cycle CPU tick
module clock_controller
  import clock_ctrl_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int DEFAULT_RATIO = 2
) (
  input logic               clock,
  input logic               reset_n,
  clock_controller_if.slave bus
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  ctrl_state_t      st;
  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] ratio_reg;
  logic [WIDTH-1:0] tick_count;
  logic             step_rise;
  logic             tick;
  logic             load;
  rising_edge_detect u_step (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (bus.step_req),
    .pulse   (step_rise)
  );
  assign tick           = (st != HALT) && (counter == ratio_reg - ONE);
  assign load           = bus.cfg_valid && (st == HALT);
  assign bus.tick       = tick;
  assign bus.cfg_ready  = st == HALT;
  assign bus.tick_count = tick_count;
  assign bus.state      = st;
  // sequencer FSM with period counter, ratio register and tick counter
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      st         <= HALT;
      counter    <= '0;
      ratio_reg  <= WIDTH'(DEFAULT_RATIO);
      tick_count <= '0;
    end else begin
      if (tick) tick_count <= tick_count + ONE;
      if (load) ratio_reg <= (bus.cfg_ratio == '0) ? ONE : bus.cfg_ratio;
      case (st)
        HALT: begin
          counter <= '0;
          if (bus.cmd_run) st <= RUN;
          else if (step_rise) st <= STEP;
        end
        RUN:
          if (!bus.cmd_run) begin
            st      <= HALT;
            counter <= '0;
          end else counter <= tick ? '0 : counter + ONE;
        STEP:
          if (tick) begin
            st      <= HALT;
            counter <= '0;
          end else counter <= counter + ONE;
        default: begin
          st      <= HALT;
          counter <= '0;
        end
      endcase
    end
endmodule

// File: tb/tb_clock_controller.sv
// tb_clock_controller: random and directed checks of two builds against a behavioural model
module tb_clock_controller;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_run = 1'b0;
  logic       step_req = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [3:0] cfg_ratio = 4'd0;
  int checks = 0;
  int fails = 0;
  // model: mode 0 halted, 1 running, 2 stepping; elapsed = cycles since entry (1 in first)
  int          m_mode;
  int          m_ratio;
  int          m_elapsed;
  logic [31:0] m_count;
  bit          m_prev;
  clock_controller_if #(.WIDTH(32)) b32 ();
  clock_controller_if #(.WIDTH(4))  b4 ();
  assign b32.cmd_run   = cmd_run;
  assign b32.step_req  = step_req;
  assign b32.cfg_valid = cfg_valid;
  assign b32.cfg_ratio = 32'(cfg_ratio);
  assign b4.cmd_run    = cmd_run;
  assign b4.step_req   = step_req;
  assign b4.cfg_valid  = cfg_valid;
  assign b4.cfg_ratio  = cfg_ratio;
  clock_controller #(.WIDTH(32), .DEFAULT_RATIO(2)) dut32 (.clock(clock), .reset_n(reset_n), .bus(b32));
  clock_controller #(.WIDTH(4), .DEFAULT_RATIO(2)) dut4 (.clock(clock), .reset_n(reset_n), .bus(b4));
  always #5 clock = ~clock;
  function automatic void model_reset();
    m_mode = 0;
    m_ratio = 2;
    m_elapsed = 0;
    m_count = 0;
    m_prev = 0;
  endfunction
  function automatic bit m_tick();
    if (m_mode == 1) return (m_elapsed % m_ratio) == 0;
    if (m_mode == 2) return m_elapsed == m_ratio;
    return 1'b0;
  endfunction
  function automatic void model_edge();
    bit t, rise;
    t = m_tick();
    rise = step_req && !m_prev;
    m_prev = step_req;
    if (t) m_count = m_count + 1;
    if (m_mode == 0) begin
      if (cfg_valid) m_ratio = (cfg_ratio == 0) ? 1 : int'(cfg_ratio);
      if (cmd_run) begin m_mode = 1; m_elapsed = 1; end
      else if (rise) begin m_mode = 2; m_elapsed = 1; end
    end else if (m_mode == 1) begin
      if (!cmd_run) m_mode = 0;
      else m_elapsed++;
    end else begin
      if (t) m_mode = 0;
      else m_elapsed++;
    end
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  // model follows the same edges and asynchronous reset as the DUTs
  always @(negedge reset_n) model_reset();
  always @(posedge clock) if (reset_n) model_edge();
  // compare both builds against the model every cycle
  always @(negedge clock) begin
    chk("tick32", 32'(b32.tick), 32'(m_tick()));
    chk("tick4", 32'(b4.tick), 32'(m_tick()));
    chk("ready32", 32'(b32.cfg_ready), 32'(m_mode == 0));
    chk("ready4", 32'(b4.cfg_ready), 32'(m_mode == 0));
    chk("state32", 32'(b32.state), 32'(m_mode));
    chk("state4", 32'(b4.state), 32'(m_mode));
    chk("count32", b32.tick_count, m_count);
    chk("count4", 32'(b4.tick_count), 32'(m_count[3:0]));
  end
  initial begin
    model_reset();
    step(2);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_tick", 32'(b32.tick), 32'd0);
    chk("rst_ready", 32'(b32.cfg_ready), 32'd1);
    chk("rst_state", 32'(b32.state), 32'd0);
    chk("rst_count", b32.tick_count, 32'd0);
    // ratio 4, 20 run cycles
    step(1);
    cfg_valid = 1'b1;
    cfg_ratio = 4'd4;
    step(1);
    cfg_valid = 1'b0;
    cmd_run = 1'b1;
    step(20);
    cmd_run = 1'b0;
    step(3);
    @(negedge clock);
    chk("run4_count", b32.tick_count, 32'd5);
    chk("run4_state", 32'(b32.state), 32'd0);
    // ratio 3, step held high
    step(1);
    cfg_valid = 1'b1;
    cfg_ratio = 4'd3;
    step(1);
    cfg_valid = 1'b0;
    step_req = 1'b1;
    step(10);
    step_req = 1'b0;
    step(2);
    @(negedge clock);
    chk("step_count", b32.tick_count, 32'd6);
    chk("step_state", 32'(b32.state), 32'd0);
    // run and step edge together: run wins
    step(1);
    cmd_run = 1'b1;
    step_req = 1'b1;
    step(1);
    @(negedge clock);
    chk("both_state", 32'(b32.state), 32'd1);
    cmd_run = 1'b0;
    step_req = 1'b0;
    step(2);
    @(negedge clock);
    chk("both_count", b32.tick_count, 32'd6);
    // ratio 0 stored as 1, load held off during run
    step(1);
    cfg_valid = 1'b1;
    cfg_ratio = 4'd0;
    step(1);
    cfg_valid = 1'b0;
    cmd_run = 1'b1;
    step(5);
    cfg_valid = 1'b1;
    cfg_ratio = 4'd7;
    step(3);
    @(negedge clock);
    chk("run_ready", 32'(b32.cfg_ready), 32'd0);
    chk("run_tick1", 32'(b32.tick), 32'd1);
    cmd_run = 1'b0;
    step(2);
    cfg_valid = 1'b0;
    @(negedge clock);
    chk("r1_count", b32.tick_count, 32'd14);
    step(1);
    cmd_run = 1'b1;
    step(7);
    cmd_run = 1'b0;
    step(1);
    @(negedge clock);
    chk("r7_count", b32.tick_count, 32'd15);
    // reset in the middle of a ratio-8 step
    step(1);
    cfg_valid = 1'b1;
    cfg_ratio = 4'd8;
    step(1);
    cfg_valid = 1'b0;
    step_req = 1'b1;
    step(4);
    reset_n = 1'b0;
    #1;
    chk("mid_tick", 32'(b32.tick), 32'd0);
    chk("mid_state", 32'(b32.state), 32'd0);
    chk("mid_ready", 32'(b4.cfg_ready), 32'd1);
    chk("mid_count", 32'(b4.tick_count), 32'd0);
    step(1);
    reset_n = 1'b1;
    step_req = 1'b0;
    cmd_run = 1'b1;
    step(4);
    cmd_run = 1'b0;
    step(1);
    @(negedge clock);
    chk("dflt_count", b32.tick_count, 32'd2);
    // narrow counter wraps
    step(1);
    cfg_valid = 1'b1;
    cfg_ratio = 4'd0;
    step(1);
    cfg_valid = 1'b0;
    cmd_run = 1'b1;
    step(20);
    cmd_run = 1'b0;
    step(1);
    @(negedge clock);
    chk("wrap4", 32'(b4.tick_count), 32'd6);
    chk("wrap32", b32.tick_count, 32'd22);
    // random phase
    for (int i = 0; i < 4000; i++) begin
      step(1);
      if ($urandom_range(0, 7) == 0) cmd_run = ~cmd_run;
      if ($urandom_range(0, 2) == 0) step_req = ~step_req;
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ratio = ($urandom_range(0, 9) == 0) ? 4'(15) : 4'($urandom_range(0, 6));
      if ($urandom_range(0, 499) == 0) begin
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
      end
    end
    @(negedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end
endmodule
